// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a byte-lane-writable word memory.
// Response appears WAIT_CYCLES+1 cycles after accept; held until resp_ready, req_ready low until then.
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rdy_q;
    logic        lat_write;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic          accept, access;
    logic          acc_write, acc_err;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;

    // rdy_q is only ever set when the FSM is (or is about to be) in IDLE
    assign accept = req_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait builds access at the accept edge, so use the live request there
    always_comb begin
        acc_write = (state_q == IDLE) ? req_write : lat_write;
        acc_addr  = (state_q == IDLE) ? req_addr  : lat_addr;
        acc_wdata = (state_q == IDLE) ? req_wdata : lat_wdata;
        acc_be    = (state_q == IDLE) ? req_be    : lat_be;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
        acc_idx   = acc_addr[AW+1:2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rdy_q     <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == IDLE);
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (access) begin
                err_q   <= acc_err;
                rdata_q <= (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
                if (!acc_err && acc_write) begin
                    for (int b = 0; b < 4; b++)
                        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end else if (state_q == RESP && resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = rdy_q;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: WAIT_CYCLES=2 instance for the main table and corner cases, WAIT_CYCLES=0 instance for zero-wait timing.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;

    logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
    logic [31:0] rd_a, rd_b;
    logic        r_ready, r_valid, r_err;
    logic [31:0] r_rdata;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(err_a));

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(err_b));

    assign r_ready = sel ? rdy_b : rdy_a;
    assign r_valid = sel ? vld_b : vld_a;
    assign r_rdata = sel ? rd_b  : rd_a;
    assign r_err   = sel ? err_b : err_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; request inputs are scrambled right after accept to prove latching
    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be; resp_ready = 1'b0;
        n = 0;
        while (!r_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            errs++; vec++;
            $display("FAIL txn_ready_timeout: req_ready never rose (addr 0x%08h)", a);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~wr; req_addr = a ^ 32'h4; req_wdata = ~d; req_be = ~be;
        lat = 1;
        while (!r_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = r_rdata;
        er = r_err;
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[14];
    logic [31:0] model[64];

    initial begin
        logic [31:0] rd, hold_d;
        logic        er;
        int          lat, n;

        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,  32'h11223344, 4'b0101, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'b1111, 32'hDE22BE44, 1'b0};
        tbl[4]  = '{1'b0, 32'h13,  32'h0,        4'b0000, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 32'hFC,  32'h12345678, 4'b0000, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 32'hFC,  32'h0,        4'b0000, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 32'hFC,  32'hA5A5A5A5, 4'b1000, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 32'hFC,  32'h0,        4'b0000, 32'hA5000000, 1'b0};
        tbl[10] = '{1'b1, 32'h0,   32'h01020304, 4'b0011, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h0,   32'h0,        4'b0000, 32'h00000304, 1'b0};
        tbl[12] = '{1'b1, 32'h2,   32'h77777777, 4'b1111, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 32'h0,   32'h0,        4'b0000, 32'h00000304, 1'b0};
        for (int i = 0; i < 64; i++) model[i] = 32'h0;

        // Reset state
        #12;
        chk("rst_req_ready", {31'h0, r_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, r_valid}, 32'h0);
        chk("rst_resp_rdata", r_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, r_err}, 32'h0);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("ready_before_first_edge", {31'h0, r_ready}, 32'h0);
        @(posedge clk); #1;
        chk("ready_after_first_edge", {31'h0, r_ready}, 32'h1);

        for (int i = 0; i < 14; i++) begin
            txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
            chk($sformatf("vec%0d_latency", i), lat, 3);
            if (tbl[i].wr && tbl[i].addr[1:0] == 2'b00 && tbl[i].addr[31:2] < 30'd64)
                for (int b = 0; b < 4; b++)
                    if (tbl[i].be[b]) model[tbl[i].addr[7:2]][8*b +: 8] = tbl[i].wdata[8*b +: 8];
        end

        for (int w = 0; w < 64; w++) begin
            txn(1'b0, 32'(w * 4), 32'h0, 4'b0000, rd, er, lat);
            chk($sformatf("sweep_word%0d", w), rd, model[w]);
        end

        // Backpressure: response held while resp_ready stays low
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'b0000; resp_ready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        n = 0;
        while (!r_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_valid_rise", {31'h0, r_valid}, 32'h1);
        hold_d = model[4];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
            @(posedge clk); #1; req_valid = 1'b0;
            chk("bp_valid_hold", {31'h0, r_valid}, 32'h1);
            chk("bp_rdata_hold", r_rdata, hold_d);
            chk("bp_err_hold", {31'h0, r_err}, 32'h0);
            chk("bp_ready_low", {31'h0, r_ready}, 32'h0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        chk("bp_done_valid", {31'h0, r_valid}, 32'h0);
        chk("bp_done_rdata", r_rdata, 32'h0);
        chk("bp_done_ready", {31'h0, r_ready}, 32'h1);
        @(posedge clk); #1;
        chk("bp_no_stray_accept", {31'h0, r_valid}, 32'h0);
        txn(1'b0, 32'h0, 32'h0, 4'b0000, rd, er, lat);
        chk("bp_word0_untouched", rd, model[0]);

        // Reset during WAIT aborts the store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("mw_in_wait_valid", {31'h0, r_valid}, 32'h0);
        chk("mw_in_wait_ready", {31'h0, r_ready}, 32'h0);
        #1; rst = 1'b0;
        #1;
        chk("mw_rst_ready", {31'h0, r_ready}, 32'h0);
        chk("mw_rst_valid", {31'h0, r_valid}, 32'h0);
        chk("mw_rst_rdata", r_rdata, 32'h0);
        @(negedge clk); rst = 1'b1;
        txn(1'b0, 32'h8, 32'h0, 4'b0000, rd, er, lat);
        chk("mw_load8", rd, 32'h0);
        chk("mw_load8_err", {31'h0, er}, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        chk("mw_mem_cleared", rd, 32'h0);

        // Zero-wait instance
        sel = 1'b1;
        txn(1'b1, 32'h4, 32'h89ABCDEF, 4'b1111, rd, er, lat);
        chk("w0_store_latency", lat, 1);
        chk("w0_store_err", {31'h0, er}, 32'h0);
        txn(1'b0, 32'h4, 32'h0, 4'b0000, rd, er, lat);
        chk("w0_load_latency", lat, 1);
        chk("w0_load_rdata", rd, 32'h89ABCDEF);
        txn(1'b0, 32'h104, 32'h0, 4'b0000, rd, er, lat);
        chk("w0_range_err", {31'h0, er}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
